// File: rtl/siggen_pkg.sv
// Shared types and helpers for the signal-generator address path.
package siggen_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Port-2 address: accumulator top bits plus phase offset. Callers truncate
  // the result to their address width, which yields the modulo wrap.
  function automatic logic [31:0] addr2_of(input logic [31:0] acc_top,
                                           input logic [31:0] off);
    return acc_top + off;
  endfunction

endpackage

// File: rtl/phase_addr_gen_if.sv
// Control and address bus between the signal-generator sequencer and the
// phase address generator.
interface phase_addr_gen_if
  import siggen_pkg::*;
#(
  parameter int ACC_WIDTH     = 16,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
);
  // No valid/ready pairs here: start, stop and en are level strobes sampled
  // on every rising clk edge, and wrap/done are one-cycle registered pulses
  // that the consumer must catch in the cycle they are high.
  logic                     en;
  logic                     start;
  logic                     stop;
  logic [ACC_WIDTH-1:0]     incr;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [7:0]               burst_len;
  logic [ADDRESS_WIDTH-1:0] addr1;
  logic [ADDRESS_WIDTH-1:0] addr2;
  logic                     wrap;
  logic                     busy;
  logic                     done;
  state_t                   dbg_state;

  modport master (
    output en, start, stop, incr, offset, burst_len,
    input  addr1, addr2, wrap, busy, done, dbg_state
  );

  modport slave (
    input  en, start, stop, incr, offset, burst_len,
    output addr1, addr2, wrap, busy, done, dbg_state
  );

endinterface

// File: rtl/phase_acc.sv
// Phase accumulator register with carry out; exposes the top bits of the
// value it will hold after this edge so callers can register addresses.
module phase_acc #(
  parameter int ACC_WIDTH     = 16,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic [ACC_WIDTH-1:0]     incr,
  output logic [ADDRESS_WIDTH-1:0] next_phase,
  output logic                     carry
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry_out;

  assign {carry_out, sum} = {1'b0, acc} + {1'b0, incr};

  // Carry is reported even when clear wins, so the owner decides priority.
  assign carry = en & carry_out;

  always_comb begin
    acc_next = acc;
    if (clear) begin
      acc_next = '0;
    end else if (en) begin
      acc_next = sum;
    end
  end

  assign next_phase = acc_next[ACC_WIDTH-1 -: ADDRESS_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/phase_addr_gen.sv
// Phase-accumulator address generator for the dual-port sine ROM: continuous
// or burst mode, with tuning word and offset retuned only at waveform wrap.
module phase_addr_gen
  import siggen_pkg::*;
#(
  parameter int ACC_WIDTH     = 16,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input logic               clk,
  input logic               rst,
  phase_addr_gen_if.slave   bus
);

  state_t                   state;
  logic [ACC_WIDTH-1:0]     incr_act;
  logic [ADDRESS_WIDTH-1:0] offset_act;
  logic [7:0]               len_act;
  logic [7:0]               wrap_cnt;
  logic [ADDRESS_WIDTH-1:0] addr1_q;
  logic [ADDRESS_WIDTH-1:0] addr2_q;
  logic                     wrap_q;
  logic                     busy_q;
  logic                     done_q;

  logic                     acc_en;
  logic                     acc_clear;
  logic [ADDRESS_WIDTH-1:0] next_phase;
  logic                     carry;
  logic [7:0]               cnt_next;
  logic                     burst_end;

  assign cnt_next  = wrap_cnt + 8'd1;
  assign acc_en    = (state == RUN) && bus.en;
  assign burst_end = (state == RUN) && carry && (len_act != 8'd0) &&
                     (cnt_next == len_act);
  assign acc_clear = (state == IDLE) || bus.stop || burst_end;

  phase_acc #(
    .ACC_WIDTH     (ACC_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .en         (acc_en),
    .clear      (acc_clear),
    .incr       (incr_act),
    .next_phase (next_phase),
    .carry      (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      incr_act   <= '0;
      offset_act <= '0;
      len_act    <= '0;
      wrap_cnt   <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          addr1_q <= '0;
          busy_q  <= 1'b0;
          if (bus.start) begin
            incr_act   <= bus.incr;
            offset_act <= bus.offset;
            len_act    <= bus.burst_len;
            wrap_cnt   <= '0;
            addr2_q    <= bus.offset;
            busy_q     <= 1'b1;
            state      <= RUN;
          end else begin
            addr2_q <= offset_act;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            addr1_q <= '0;
            addr2_q <= offset_act;
          end else if (carry) begin
            // Retune on the wrap edge; the new offset applies to this edge's addr2.
            incr_act   <= bus.incr;
            offset_act <= bus.offset;
            wrap_cnt   <= cnt_next;
            wrap_q     <= 1'b1;
            if (burst_end) begin
              state   <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              addr1_q <= '0;
              addr2_q <= bus.offset;
            end else begin
              addr1_q <= next_phase;
              addr2_q <= ADDRESS_WIDTH'(addr2_of(32'(next_phase), 32'(bus.offset)));
            end
          end else begin
            addr1_q <= next_phase;
            addr2_q <= ADDRESS_WIDTH'(addr2_of(32'(next_phase), 32'(offset_act)));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr1     = addr1_q;
  assign bus.addr2     = addr2_q;
  assign bus.wrap      = wrap_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;

endmodule
